// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file scoreboard.
// Decode and writeback drive through master; the register file uses slave.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] ru1;
    logic [XLEN-1:0] ru2;
    logic            wr_en;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data_wr;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic            busy1;
    logic            busy2;
    logic            hazard;
    logic            issue_stall;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    // Handshake: an issue is accepted on a rising edge when issue_en=1 and
    // issue_stall=0; a stalled issue is dropped and must be held by decode.
    // wr_en is a retire strobe with no back-pressure.
    modport master (
        output rs1, rs2, use_rs1, use_rs2, wr_en, rd, data_wr,
               issue_en, issue_rd, flush, dbg_addr,
        input  ru1, ru2, busy1, busy2, hazard, issue_stall, dbg_data
    );

    modport slave (
        input  rs1, rs2, use_rs1, use_rs2, wr_en, rd, data_wr,
               issue_en, issue_rd, flush, dbg_addr,
        output ru1, ru2, busy1, busy2, hazard, issue_stall, dbg_data
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read bypass and per-register pending-write counters.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
    localparam logic [AW-1:0]     ADDR_ZERO = '0;
    localparam bit                BYP_ON = (BYPASS != 0);

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [PEND_W-1:0] r_cnt  [NREGS];

    logic w_wr_act;
    logic w_stall;
    logic w_inc;
    logic w_dec;
    logic w_byp1;
    logic w_byp2;
    logic w_busy1;
    logic w_busy2;

    assign w_wr_act = bus.wr_en && (bus.rd != ADDR_ZERO);

    // A retire to the same register in the same cycle frees a slot, so a
    // saturated counter only stalls when no matching write is retiring.
    assign w_stall = (bus.issue_rd != ADDR_ZERO) &&
                     (r_cnt[bus.issue_rd] == CNT_MAX) &&
                     !(bus.wr_en && (bus.rd == bus.issue_rd));

    assign w_inc = bus.issue_en && (bus.issue_rd != ADDR_ZERO) && !w_stall;
    assign w_dec = w_wr_act && (r_cnt[bus.rd] != '0);

    assign w_byp1 = BYP_ON && w_wr_act && (bus.rd == bus.rs1);
    assign w_byp2 = BYP_ON && w_wr_act && (bus.rd == bus.rs2);

    // Only the last outstanding write may resolve the hazard through bypass.
    assign w_busy1 = (r_cnt[bus.rs1] != '0) &&
                     !(w_byp1 && (r_cnt[bus.rs1] == CNT_ONE));
    assign w_busy2 = (r_cnt[bus.rs2] != '0) &&
                     !(w_byp2 && (r_cnt[bus.rs2] == CNT_ONE));

    assign bus.ru1         = w_byp1 ? bus.data_wr : r_regs[bus.rs1];
    assign bus.ru2         = w_byp2 ? bus.data_wr : r_regs[bus.rs2];
    assign bus.busy1       = w_busy1;
    assign bus.busy2       = w_busy2;
    assign bus.hazard      = (bus.use_rs1 && w_busy1) || (bus.use_rs2 && w_busy2);
    assign bus.issue_stall = w_stall;
    assign bus.dbg_data    = r_regs[bus.dbg_addr];

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_act) begin
            r_regs[bus.rd] <= bus.data_wr;
        end
    end

    // Flush wins over inc/dec; an inc and dec on one register cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_inc && (bus.issue_rd == AW'(i)) &&
                    !(w_dec && (bus.rd == AW'(i)))) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end else if (w_dec && (bus.rd == AW'(i)) &&
                             !(w_inc && (bus.issue_rd == AW'(i)))) begin
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
                end
            end
        end
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file for the pipelined core, with a built-in write scoreboard. It provides two combinational read ports and one write port, with optional same-cycle write-to-read bypass. A per-register pending-write counter lets decode detect RAW hazards and stall without a separate hazard unit. It sits between decode (read/issue side) and writeback (write/retire side).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >=2); register 0 hardwired to zero
AW, $clog2(NREGS), register address width (derived, not overridden)
PEND_W, 2, width of each pending-write counter; max outstanding writes per register = 2^PEND_W-1
BYPASS, 1, 1 = write data forwarded to read ports in the same cycle; 0 = reads see only stored values

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rs1  in  AW  read address, port 1
rs2  in  AW  read address, port 2
use_rs1  in  1  decode actually consumes rs1 this cycle
use_rs2  in  1  decode actually consumes rs2 this cycle
ru1  out  XLEN  read data, port 1
ru2  out  XLEN  read data, port 2
wr_en  in  1  writeback valid (retire)
rd  in  AW  writeback destination
data_wr  in  XLEN  writeback data
issue_en  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  AW  destination of the issuing instruction
flush  in  1  pipeline flush: discard all pending-write bookkeeping
busy1  out  1  rs1 has an unresolved pending write
busy2  out  1  rs2 has an unresolved pending write
hazard  out  1  (use_rs1&busy1)|(use_rs2&busy2)
issue_stall  out  1  counter for issue_rd is saturated; an issue would be dropped
dbg_addr  in  AW  debug/bench read address
dbg_data  out  XLEN  stored value of register dbg_addr (no bypass)

Behaviour:
- Reset (rst_n=0, asynchronous): all registers=0; all counters=0. Outputs then: ru1=ru2=dbg_data=0; busy1=busy2=hazard=issue_stall=0. Reset mid-operation aborts all pending state immediately.
- Register 0: reads always 0; writes ignored; never counted as pending (issue_rd=0 and rd=0 leave counter 0 untouched); busy/issue_stall never asserted for address 0.
- Write: on rising edge, if wr_en and rd!=0, reg[rd]<=data_wr. Takes effect on the next cycle's stored value.
- Read: combinational. If BYPASS=1 and wr_en and rd==rsX and rd!=0, ruX=data_wr; otherwise ruX=reg[rsX].
- Counters cnt[r] (PEND_W bits), updated on rising edge:
  - inc = issue_en & issue_rd!=0 & !issue_stall
  - dec = wr_en & rd!=0 & cnt[rd]!=0
  - If inc and dec target the same register, its counter is unchanged.
  - A write to a register with cnt=0 stores the data; the counter stays 0 (no underflow).
- issue_stall = (issue_rd!=0) & cnt[issue_rd]==max & !(wr_en & rd==issue_rd). An issue while issue_stall=1 is dropped (counter unchanged); the issuer must hold it.
- busyX = cnt[rsX]!=0 & !(BYPASS & wr_en & rd==rsX & cnt[rsX]==1). Only the last outstanding write resolves the hazard through bypass. With BYPASS=0, busy clears the cycle after the final retire.
- flush: on the rising edge, all counters are set to 0. Flush has priority over inc/dec in the same cycle. A wr_en in the same cycle still writes data. Register contents are never cleared by flush.
- All register-read and hazard outputs are purely combinational from current state and inputs: zero-latency decode check.

Test Plan:
- Reset then read: after rst_n deasserts, rs1=5, rs2=31 -> ru1=ru2=0, busy1=busy2=hazard=0; dbg_data=0 for all addresses.
- x0 protection: wr_en=1, rd=0, data_wr=32'hDEADBEEF; issue_en=1, issue_rd=0 -> next cycle ru1(rs1=0)=0, busy1=0, issue_stall=0.
- Bypass and RAW: issue x7; next cycle rs1=7, use_rs1=1 -> busy1=1, hazard=1. Then wr_en, rd=7, data_wr=32'h1234 -> same cycle ru1=32'h1234, busy1=0, hazard=0 (BYPASS=1). Repeat with BYPASS=0 -> ru1=old value and busy1=1 that cycle; next cycle busy1=0 and ru1=32'h1234.
- Multiple outstanding / saturation (PEND_W=2): issue x3 three times -> issue_stall=1 with issue_rd=3; a fourth issue is dropped. Retire x3 once -> cnt=2, busy stays 1. Same-cycle issue+retire on x3 leaves cnt unchanged.
- Flush: issue x4 and x9, assert flush with a simultaneous wr_en rd=4 data=32'hA5 -> next cycle busy=0 for x4 and x9, reg[4]=32'hA5. A later wr_en rd=9 writes data with no underflow.
- Async reset mid-stream: with counters nonzero and reg[2]=32'hFF, pulse rst_n low between clock edges -> outputs clear immediately, before the next edge.
